// File: rtl/serial_sbox_layer_pkg.sv
// Shared constants, state encoding and helpers for the serial S-box layer.
package serial_sbox_pkg;

  localparam int W_DEF      = 6;  // S-box word width (GF(2^6) element)
  localparam int NWORDS_DEF = 8;  // words per state

  // Word-index width; kept at least 1 bit so a single-word state still elaborates.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDX_W_DEF = idx_width(NWORDS_DEF);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_sbox_layer_if.sv
// Bus bundle for the serial S-box layer: upstream handshake, downstream
// handshake, the external S-box tap and the busy flag.
interface serial_sbox_if #(
  parameter int W      = 6,
  parameter int NWORDS = 8
);
  logic                in_valid;
  logic                in_ready;
  logic [NWORDS*W-1:0] in_data;
  logic [W-1:0]        sbox_x;
  logic [W-1:0]        sbox_y;
  logic                out_valid;
  logic                out_ready;
  logic [NWORDS*W-1:0] out_data;
  logic                busy;

  // Block side.
  modport slave (
    input  in_valid, in_data, sbox_y, out_ready,
    output in_ready, sbox_x, out_valid, out_data, busy
  );

  // Parent side: upstream, downstream and the S-box wiring.
  modport master (
    output in_valid, in_data, sbox_y, out_ready,
    input  in_ready, sbox_x, out_valid, out_data, busy
  );
endinterface

// File: rtl/serial_sbox_layer_word_shift_reg.sv
// NWORDS*W state register: parallel load, shift right one word with a new
// word inserted at the top, and a tap on the lowest word.
module word_shift_reg #(
  parameter int W      = 6,
  parameter int NWORDS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_load,
  input  logic [NWORDS*W-1:0] i_load_data,
  input  logic                i_shift,
  input  logic [W-1:0]        i_shift_in,
  output logic [NWORDS*W-1:0] o_data,
  output logic [W-1:0]        o_low
);

  logic [NWORDS*W-1:0] r_data;
  logic [NWORDS*W-1:0] w_shifted;

  generate
    if (NWORDS > 1) begin : g_multi
      assign w_shifted = {i_shift_in, r_data[NWORDS*W-1:W]};
    end else begin : g_single
      assign w_shifted = i_shift_in;
    end
  endgenerate

  // Load wins over shift; i_shift_in is only consumed while shifting.
  always_ff @(posedge clk) begin
    if (rst)          r_data <= '0;
    else if (i_load)  r_data <= i_load_data;
    else if (i_shift) r_data <= w_shifted;
  end

  assign o_data = r_data;
  assign o_low  = r_data[W-1:0];

endmodule

// File: rtl/serial_sbox_layer.sv
// Serial S-box layer: pushes one word per cycle through a single external
// combinational S-box, rotating the substituted word back in at the top so
// that after NWORDS cycles every word sits in its original slot.
module serial_sbox_layer
  import serial_sbox_pkg::*;
#(
  parameter int W      = W_DEF,
  parameter int NWORDS = NWORDS_DEF
) (
  input  logic          clk,
  input  logic          rst,
  serial_sbox_if.slave  bus
);

  localparam int IDXW = idx_width(NWORDS);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NWORDS - 1);

  state_e              r_state, w_next_state;
  logic [IDXW-1:0]     r_idx;
  logic                w_load, w_shift, w_in_ready;
  logic [NWORDS*W-1:0] w_sreg;
  logic [W-1:0]        w_low;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // Next state, load/shift strobes and upstream ready.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    w_in_ready   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_load       = 1'b1;
          w_next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        w_shift = 1'b1;
        if (r_idx == LAST_IDX) w_next_state = ST_DONE;
      end
      ST_DONE: begin
        // Release and reload in the same cycle so back-to-back states see no bubble.
        if (bus.out_ready) begin
          w_in_ready = 1'b1;
          if (bus.in_valid) begin
            w_load       = 1'b1;
            w_next_state = ST_RUN;
          end else begin
            w_next_state = ST_IDLE;
          end
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Word counter: cleared on load, advanced once per RUN cycle.
  always_ff @(posedge clk) begin
    if (rst)          r_idx <= '0;
    else if (w_load)  r_idx <= '0;
    else if (w_shift) r_idx <= r_idx + IDXW'(1);
  end

  word_shift_reg #(
    .W      (W),
    .NWORDS (NWORDS)
  ) u_sreg (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_load),
    .i_load_data (bus.in_data),
    .i_shift     (w_shift),
    .i_shift_in  (bus.sbox_y),
    .o_data      (w_sreg),
    .o_low       (w_low)
  );

  assign bus.in_ready  = w_in_ready;
  // Gate the S-box input outside RUN so the external logic stays quiet.
  assign bus.sbox_x    = (r_state == ST_RUN) ? w_low : '0;
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.out_data  = w_sreg;
  assign bus.busy      = (r_state == ST_RUN);

endmodule

// File: tb/tb_serial_sbox_layer.sv
// Bench for serial_sbox_layer: directed cases plus a randomized scoreboard run.
// The S-box is modelled behaviourally; outside RUN sbox_y carries random junk.
module tb_serial_sbox_layer;

  localparam int W  = 6;
  localparam int NW = 8;
  localparam int SW = W * NW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_sbox_if #(.W(W), .NWORDS(NW)) bus();

  serial_sbox_layer #(.W(W), .NWORDS(NW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int mode   = 0;            // 0 identity, 1 bitwise NOT, 2 table
  logic [5:0] junk = 6'd0;
  logic [5:0] tbl [64];

  function automatic logic [5:0] sbox_f(input logic [5:0] x);
    case (mode)
      0:       return x;
      1:       return ~x;
      default: return tbl[x];
    endcase
  endfunction

  // Reference: every word replaced by its S-box image, order preserved.
  function automatic logic [SW-1:0] model(input logic [SW-1:0] d);
    logic [SW-1:0] r;
    r = '0;
    for (int i = 0; i < NW; i++) r[i*W +: W] = sbox_f(d[i*W +: W]);
    return r;
  endfunction

  always @(posedge clk) junk <= 6'($urandom);
  assign bus.sbox_y = bus.busy ? sbox_f(bus.sbox_x) : junk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Called at a negedge; returns at the negedge of the first RUN cycle.
  task automatic launch(input logic [SW-1:0] d);
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    #1;
    chk("in_ready_at_load", bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Starts at RUN cycle 1; follows the run until out_valid.
  task automatic collect(input logic [SW-1:0] d);
    int k  = 1;
    int nb = 0;
    logic [SW-1:0] seq = '0;
    #1;
    while (!bus.out_valid && k < 40) begin
      if (bus.busy) begin
        if (nb < NW) seq[nb*W +: W] = bus.sbox_x;
        nb++;
      end
      @(negedge clk);
      #1;
      k++;
    end
    chk("latency", k, NW + 1);
    chk("busy_cycles", nb, NW);
    chk("sbox_x_seq", seq, d);
    chk("out_data", bus.out_data, model(d));
  endtask

  task automatic release_to_idle();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    #1;
    chk("idle_out_valid", bus.out_valid, 0);
    chk("idle_in_ready", bus.in_ready, 1);
    chk("idle_sbox_x", bus.sbox_x, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [SW-1:0] d, d2, od, pend;
    logic [SW-1:0] q [$];
    int acc, outs, cyc;

    for (int i = 0; i < 64; i++) tbl[i] = 6'((i * i * 7 + i * 13 + 5) ^ (i >> 1));

    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_sbox_x", bus.sbox_x, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    @(negedge clk);

    // 1: identity
    mode = 0;
    launch(48'h123456789ABC);
    collect(48'h123456789ABC);
    chk("ident_const", bus.out_data, 48'h123456789ABC);
    release_to_idle();

    // 2: NOT of zero
    @(negedge clk);
    mode = 1;
    launch('0);
    collect('0);
    chk("not_const", bus.out_data, 48'hFFFFFFFFFFFF);
    release_to_idle();

    // 3: table, words 0..7
    @(negedge clk);
    mode = 2;
    for (int i = 0; i < NW; i++) d[i*W +: W] = 6'(i);
    launch(d);
    collect(d);
    release_to_idle();

    // 4: backpressure then same-cycle release/reload
    @(negedge clk);
    d  = 48'({$urandom(), $urandom()});
    d2 = 48'({$urandom(), $urandom()});
    launch(d);
    collect(d);
    od = bus.out_data;
    bus.in_valid = 1'b1;
    bus.in_data  = d2;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_stable", bus.out_data, od);
      chk("bp_in_ready", bus.in_ready, 0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", bus.in_ready, 1);
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    #1;
    chk("bp_reload_busy", bus.busy, 1);
    chk("bp_reload_valid", bus.out_valid, 0);
    collect(d2);
    release_to_idle();

    // 5: reset in RUN cycle 4
    @(negedge clk);
    d = 48'({$urandom(), $urandom()});
    launch(d);
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", bus.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_out_data", bus.out_data, 0);
    chk("mid_rst_in_ready", bus.in_ready, 1);
    chk("mid_rst_busy", bus.busy, 0);
    @(negedge clk);
    d = 48'({$urandom(), $urandom()});
    launch(d);
    collect(d);
    release_to_idle();

    // 6: random valid/ready traffic against a scoreboard
    @(negedge clk);
    acc  = 0;
    outs = 0;
    cyc  = 0;
    pend = 48'({$urandom(), $urandom()});
    while ((acc < 100 || q.size() > 0) && cyc < 6000) begin
      bus.in_valid  = (acc < 100) && ($urandom_range(0, 2) != 0);
      bus.in_data   = pend;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (bus.busy) chk("run_in_ready", bus.in_ready, 0);
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) chk("sb_unexpected", 1, 0);
        else chk("sb_out", bus.out_data, model(q.pop_front()));
        outs++;
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(pend);
        acc++;
        pend = 48'({$urandom(), $urandom()});
      end
      @(negedge clk);
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("sb_no_timeout", (cyc < 6000), 1);
    chk("sb_count", outs, 100);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
